mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

CPU-side initiator for the MOV/MOC memory handshake used by the 512x8 RAM. It accepts one load/store request per transaction from the datapath control unit. It drives MOV, ReadWrite, Address, OpCode and DataIn toward memory, waits for MOC, and returns read data with a one-cycle completion pulse. Doubleword accesses are sequenced as two 32-bit halves, tracked against the memory's DMOC flag.

## Interface
- TIMEOUT, 16: maximum cycles spent waiting for MOC in one half before aborting with error.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high in IDLE only; request accepted on req_valid && req_ready.
- req_opcode  in  6  MIPS load/store opcode.
- req_addr  in  9  byte address.
- req_wdata_hi  in  32  store data (first/only half).
- req_wdata_lo  in  32  second half, doubleword store only.
- done  out  1  one-cycle pulse when the transaction ends.
- err  out  1  valid with done: timeout, DMOC mismatch, or illegal opcode.
- rdata_hi  out  32  load data (first/only half); held until next accept.
- rdata_lo  out  32  second half, doubleword load only; held until next accept.
- MOV  out  1  memory operation valid; registered.
- ReadWrite  out  1  1=read, 0=write; registered.
- Address  out  9  registered byte address.
- OpCode  out  6  registered opcode.
- DataIn  out  32  store data to memory; registered.
- DataOut  in  32  read data from memory.
- MOC  in  1  memory operation complete.
- DMOC  in  1  memory doubleword phase flag.

## Operation
- Legal reads: 110101 (dword), 100011, 100101, 100001, 100100, 100000.
- Legal writes: 111101 (dword), 101011, 101001, 101000.
- ReadWrite=1 for reads and 0 for writes.
- Illegal opcode: accepted, no MOV issued, done=1 and err=1 the next cycle.
- States:
  - IDLE: req_ready=1. On accept, latch opcode, addr and both wdata words; load Address/OpCode/ReadWrite; set DataIn=wdata_hi; clear err; go to ISSUE.
  - ISSUE: MOV=1. MOC is ignored, because it is stale-high from the previous operation. Go to WAIT.
  - WAIT: MOV=1; timeout counter runs. On MOC=1: for reads, latch DataOut into rdata_hi (half 0) or rdata_lo (half 1).
    - Dword half 0: go to GAP.
    - Otherwise: go to DONE.
    - If counter reaches TIMEOUT without MOC: set err and go to DONE.
  - GAP: MOV=0 for exactly one cycle. Check DMOC==1, else set err. Set DataIn=wdata_lo and half=1, then go to ISSUE. Address is unchanged; memory applies the +4 offset.
  - DONE: MOV=0, done=1. For dword, check DMOC==0, else set err. Go to IDLE.
- No sign/zero extension is done here; memory returns extended data, passed through unchanged.
- MOV always falls for at least one cycle between any two memory operations, because memory is edge-triggered on MOV.
- Address, OpCode, ReadWrite and DataIn are stable for the whole time MOV is high.

## Timing
- Reset values: MOV=0, ReadWrite=1, Address=0, OpCode=0, DataIn=0, done=0, err=0, rdata_hi=0, rdata_lo=0, req_ready=1, state=IDLE, timeout counter=0.
- Single access with MOC ready: accept at edge E0; MOV high during cycles 1–2; MOC sampled at E2; done high during cycle 3; req_ready high again in cycle 4. Latency is 3 cycles to done.
- Dword access with MOC ready: MOV high during cycles 1–2 and 4–5, low during cycle 3 (GAP); done in cycle 6.
- Each extra cycle MOC stays low adds one cycle. The timeout counter resets on entering ISSUE.
- Timeout: abort after TIMEOUT WAIT cycles, with MOV=0 and done=err=1 the next cycle.
- req_valid while busy: ignored, no queueing. Back-to-back requests: next accept is in the cycle after done, so MOV is low for at least 2 cycles between transactions.
- Reset mid-transaction: all outputs return to reset values at the reset edge, no done pulse, and rdata is cleared.

## Test plan
- Word store 0xDEADBEEF to addr 0x010 (op 101011), then word load (op 100011) from 0x010 -> each done 3 cycles after accept, err=0, rdata_hi=0xDEADBEEF; MOV low between ops.
- Dword store hi=0x11223344, lo=0x55667788 to 0x020 (op 111101), then dword load (op 110101) -> two MOV pulses with a 1-cycle gap each, DMOC 1 then 0, rdata_hi=0x11223344, rdata_lo=0x55667788, done at cycle 6, err=0.
- Signed byte load (op 100000) of 0x80 -> rdata_hi=0xFFFFFF80. Unsigned halfword load (op 100101) of 0x8001 -> rdata_hi=0x00008001.
- MOC model stalled low, TIMEOUT=16 -> MOV high for exactly 17 cycles (ISSUE plus 16 WAIT cycles), then MOV=0 and done=err=1.
- Illegal opcode 000000 -> MOV never rises; done=err=1 in cycle 1.
- Reset asserted in WAIT of a dword load -> MOV=0 next cycle, no done, all outputs at reset values. A following word load completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Bundle for the request port (datapath side) and the MOV/MOC memory bus.
// master = the controller, slave = the datapath plus memory it talks to.
interface mem_access_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_opcode;
   logic [8:0]  req_addr;
   logic [31:0] req_wdata_hi;
   logic [31:0] req_wdata_lo;
   logic        done;
   logic        err;
   logic [31:0] rdata_hi;
   logic [31:0] rdata_lo;

   logic        MOV;
   logic        ReadWrite;
   logic [8:0]  Address;
   logic [5:0]  OpCode;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        MOC;
   logic        DMOC;

   modport master (
      input  req_valid, req_opcode, req_addr, req_wdata_hi, req_wdata_lo,
      output req_ready, done, err, rdata_hi, rdata_lo,
      output MOV, ReadWrite, Address, OpCode, DataIn,
      input  DataOut, MOC, DMOC
   );

   modport slave (
      output req_valid, req_opcode, req_addr, req_wdata_hi, req_wdata_lo,
      input  req_ready, done, err, rdata_hi, rdata_lo,
      input  MOV, ReadWrite, Address, OpCode, DataIn,
      output DataOut, MOC, DMOC
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// CPU-side MOV/MOC initiator for the 512x8 RAM: one load/store per transaction,
// doublewords issued as two 32-bit halves checked against DMOC.
module mem_access_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   mem_access_ctrl_if.master bus
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE} state_t;

   state_t        state, state_nx;
   logic          mov_q, rw_q, half_q, err_q;
   logic [8:0]    addr_q;
   logic [5:0]    op_q;
   logic [31:0]   din_q, wlo_q, rhi_q, rlo_q;
   logic [CW-1:0] cnt_q;
   logic          timeout, dword_q;

   function automatic logic is_rd(input logic [5:0] op);
      case (op)
         6'b110101, 6'b100011, 6'b100101,
         6'b100001, 6'b100100, 6'b100000: is_rd = 1'b1;
         default:                         is_rd = 1'b0;
      endcase
   endfunction

   function automatic logic is_wr(input logic [5:0] op);
      case (op)
         6'b111101, 6'b101011, 6'b101001, 6'b101000: is_wr = 1'b1;
         default:                                    is_wr = 1'b0;
      endcase
   endfunction

   function automatic logic is_dw(input logic [5:0] op);
      is_dw = (op == 6'b110101) || (op == 6'b111101);
   endfunction

   assign timeout = (cnt_q == CW'(TIMEOUT - 1));
   assign dword_q = is_dw(op_q);

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (bus.req_valid)
                   state_nx = (is_rd(bus.req_opcode) || is_wr(bus.req_opcode)) ? ISSUE : DONE;
         ISSUE: state_nx = WAIT;
         WAIT:  if (bus.MOC)    state_nx = (dword_q && !half_q) ? GAP : DONE;
                else if (timeout) state_nx = DONE;
         GAP:   state_nx = ISSUE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The closing DMOC check happens live in DONE, so err is combinational there.
   always_comb begin
      bus.req_ready = 1'b0;
      bus.done      = 1'b0;
      bus.err       = 1'b0;
      unique case (state)
         IDLE: bus.req_ready = 1'b1;
         DONE: begin
            bus.done = 1'b1;
            bus.err  = err_q | (dword_q & bus.DMOC);
         end
         default: ;
      endcase
   end

   // Registered bus side and datapath. MOV is registered from next-state so it
   // drops in GAP/DONE, guaranteeing a low cycle between memory operations.
   always_ff @(posedge clk) begin
      if (reset) begin
         mov_q  <= 1'b0;
         rw_q   <= 1'b1;
         addr_q <= '0;
         op_q   <= '0;
         din_q  <= '0;
         wlo_q  <= '0;
         rhi_q  <= '0;
         rlo_q  <= '0;
         half_q <= 1'b0;
         err_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         mov_q <= (state_nx == ISSUE) || (state_nx == WAIT);
         unique case (state)
            IDLE: if (bus.req_valid) begin
               op_q   <= bus.req_opcode;
               addr_q <= bus.req_addr;
               rw_q   <= !is_wr(bus.req_opcode);
               din_q  <= bus.req_wdata_hi;
               wlo_q  <= bus.req_wdata_lo;
               half_q <= 1'b0;
               cnt_q  <= '0;
               err_q  <= !(is_rd(bus.req_opcode) || is_wr(bus.req_opcode));
            end
            WAIT: begin
               if (bus.MOC) begin
                  if (rw_q) begin
                     if (half_q) rlo_q <= bus.DataOut;
                     else        rhi_q <= bus.DataOut;
                  end
               end else if (timeout) begin
                  err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            GAP: begin
               if (!bus.DMOC) err_q <= 1'b1;
               din_q  <= wlo_q;
               half_q <= 1'b1;
               cnt_q  <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.MOV       = mov_q;
   assign bus.ReadWrite = rw_q;
   assign bus.Address   = addr_q;
   assign bus.OpCode    = op_q;
   assign bus.DataIn    = din_q;
   assign bus.rdata_hi  = rhi_q;
   assign bus.rdata_lo  = rlo_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural big-endian 512x8 RAM
// that answers each MOV rising edge and toggles DMOC across doubleword halves.
module tb_mem_access_ctrl;

   logic clk = 1'b0;
   logic reset;
   logic stall;
   int   errors = 0;
   int   checks = 0;

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(.TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // memory model
   logic [7:0] mem [0:511];
   logic       mov_d;
   logic       op_dw;
   logic [8:0] ea;

   assign op_dw = (bus.OpCode == 6'b110101) || (bus.OpCode == 6'b111101);
   assign ea    = bus.Address + ((op_dw && bus.DMOC) ? 9'd4 : 9'd0);

   function automatic logic [31:0] mrd(input logic [5:0] op, input logic [8:0] a);
      case (op)
         6'b100000: mrd = {{24{mem[a][7]}}, mem[a]};
         6'b100100: mrd = {24'h0, mem[a]};
         6'b100001: mrd = {{16{mem[a][7]}}, mem[a], mem[a + 9'd1]};
         6'b100101: mrd = {16'h0, mem[a], mem[a + 9'd1]};
         default:   mrd = {mem[a], mem[a + 9'd1], mem[a + 9'd2], mem[a + 9'd3]};
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         bus.MOC     <= 1'b0;
         bus.DMOC    <= 1'b0;
         bus.DataOut <= '0;
         mov_d       <= 1'b0;
      end else begin
         mov_d <= bus.MOV;
         if (bus.MOV && !mov_d) begin
            if (stall) begin
               bus.MOC <= 1'b0;
            end else begin
               bus.MOC <= 1'b1;
               if (op_dw) bus.DMOC <= !bus.DMOC;
               if (bus.ReadWrite) begin
                  bus.DataOut <= mrd(bus.OpCode, ea);
               end else begin
                  case (bus.OpCode)
                     6'b101000: mem[ea] <= bus.DataIn[7:0];
                     6'b101001: begin
                        mem[ea]        <= bus.DataIn[15:8];
                        mem[ea + 9'd1] <= bus.DataIn[7:0];
                     end
                     default: begin
                        mem[ea]        <= bus.DataIn[31:24];
                        mem[ea + 9'd1] <= bus.DataIn[23:16];
                        mem[ea + 9'd2] <= bus.DataIn[15:8];
                        mem[ea + 9'd3] <= bus.DataIn[7:0];
                     end
                  endcase
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One transaction: lat = cycle (after accept) in which done was seen, pat[k] = MOV in cycle k.
   task automatic txn(input logic [5:0] op, input logic [8:0] addr,
                      input logic [31:0] hi, input logic [31:0] lo,
                      output int lat, output logic e, output logic [63:0] pat,
                      output logic rdy1, output logic stable);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      bus.req_valid    = 1'b1;
      bus.req_opcode   = op;
      bus.req_addr     = addr;
      bus.req_wdata_hi = hi;
      bus.req_wdata_lo = lo;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = 0; e = 1'b0; pat = '0; rdy1 = 1'b1; stable = 1'b1;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         pat[k] = bus.MOV;
         if (k == 1) rdy1 = bus.req_ready;
         if (bus.MOV && (bus.Address !== addr || bus.OpCode !== op)) stable = 1'b0;
         if (bus.done) begin
            lat = k;
            e   = bus.err;
         end
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mov"},   bus.MOV,       0);
      chk({tag, "_rw"},    bus.ReadWrite, 1);
      chk({tag, "_addr"},  bus.Address,   0);
      chk({tag, "_op"},    bus.OpCode,    0);
      chk({tag, "_din"},   bus.DataIn,    0);
      chk({tag, "_done"},  bus.done,      0);
      chk({tag, "_err"},   bus.err,       0);
      chk({tag, "_rhi"},   bus.rdata_hi,  0);
      chk({tag, "_rlo"},   bus.rdata_lo,  0);
      chk({tag, "_ready"}, bus.req_ready, 1);
   endtask

   int          lat;
   logic        e, rdy1, stable;
   logic [63:0] pat;

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_opcode   = '0;
      bus.req_addr     = '0;
      bus.req_wdata_hi = '0;
      bus.req_wdata_lo = '0;
      repeat (2) @(posedge clk);
      #1 chk_reset_vals("rst");
      @(negedge clk) reset = 1'b0;

      // word store then word load
      txn(6'b101011, 9'h010, 32'hDEADBEEF, 32'h0, lat, e, pat, rdy1, stable);
      chk("sw_lat", lat, 3);
      chk("sw_err", e, 0);
      chk("sw_mov", pat, 64'h6);
      chk("sw_busy_ready", rdy1, 0);
      chk("sw_stable", stable, 1);
      txn(6'b100011, 9'h010, 32'h0, 32'h0, lat, e, pat, rdy1, stable);
      chk("lw_lat", lat, 3);
      chk("lw_err", e, 0);
      chk("lw_mov", pat, 64'h6);
      chk("lw_data", bus.rdata_hi, 32'hDEADBEEF);

      // doubleword store then doubleword load
      txn(6'b111101, 9'h020, 32'h11223344, 32'h55667788, lat, e, pat, rdy1, stable);
      chk("sd_lat", lat, 6);
      chk("sd_err", e, 0);
      chk("sd_mov", pat, 64'h36);
      chk("sd_stable", stable, 1);
      txn(6'b110101, 9'h020, 32'h0, 32'h0, lat, e, pat, rdy1, stable);
      chk("ld_lat", lat, 6);
      chk("ld_err", e, 0);
      chk("ld_mov", pat, 64'h36);
      chk("ld_hi", bus.rdata_hi, 32'h11223344);
      chk("ld_lo", bus.rdata_lo, 32'h55667788);

      // sign-extended byte, zero-extended halfword
      txn(6'b101000, 9'h030, 32'h00000080, 32'h0, lat, e, pat, rdy1, stable);
      chk("sb_lat", lat, 3);
      txn(6'b100000, 9'h030, 32'h0, 32'h0, lat, e, pat, rdy1, stable);
      chk("lb_data", bus.rdata_hi, 32'hFFFFFF80);
      txn(6'b101001, 9'h040, 32'h00008001, 32'h0, lat, e, pat, rdy1, stable);
      chk("sh_err", e, 0);
      txn(6'b100101, 9'h040, 32'h0, 32'h0, lat, e, pat, rdy1, stable);
      chk("lhu_data", bus.rdata_hi, 32'h00008001);

      // stalled memory: ISSUE + 16 WAIT cycles of MOV, then abort
      stall = 1'b1;
      txn(6'b100011, 9'h010, 32'h0, 32'h0, lat, e, pat, rdy1, stable);
      stall = 1'b0;
      chk("to_lat", lat, 18);
      chk("to_err", e, 1);
      chk("to_mov", pat, 64'h3FFFE);
      chk("to_rdata_held", bus.rdata_hi, 32'h00008001);

      // illegal opcode
      txn(6'b000000, 9'h000, 32'h0, 32'h0, lat, e, pat, rdy1, stable);
      chk("ill_lat", lat, 1);
      chk("ill_err", e, 1);
      chk("ill_mov", pat, 64'h0);

      // reset during WAIT of a doubleword load
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_opcode = 6'b110101;
      bus.req_addr   = 9'h020;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_mov", bus.MOV, 1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_reset_vals("midrst");

      txn(6'b100011, 9'h010, 32'h0, 32'h0, lat, e, pat, rdy1, stable);
      chk("post_rst_lat", lat, 3);
      chk("post_rst_err", e, 0);
      chk("post_rst_data", bus.rdata_hi, 32'hDEADBEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
